// File: rtl/jts16_tmap_sdram.sv
// Tile map SDRAM responder: five one-entry port caches fed from a single 16-bit
// read channel, fixed-priority miss arbitration, two-word bursts for 32-bit ports.
module jts16_tmap_sdram #(
  parameter logic [21:0] CHAR_OFFSET = 22'h0,
  parameter logic [21:0] SCR1_OFFSET = 22'h0,
  parameter logic [21:0] SCR2_OFFSET = 22'h0,
  parameter logic [21:0] MAP1_OFFSET = 22'h0,
  parameter logic [21:0] MAP2_OFFSET = 22'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [12:0] char_addr,
  output logic        char_ok,
  output logic [31:0] char_data,
  input  logic [16:0] scr1_addr,
  output logic        scr1_ok,
  output logic [31:0] scr1_data,
  input  logic [16:0] scr2_addr,
  output logic        scr2_ok,
  output logic [31:0] scr2_data,
  input  logic [14:0] map1_addr,
  output logic        map1_ok,
  output logic [15:0] map1_data,
  input  logic [14:0] map2_addr,
  output logic        map2_ok,
  output logic [15:0] map2_data,
  output logic        sdram_req,
  output logic [21:0] sdram_addr,
  input  logic        sdram_gnt,
  input  logic        sdram_rdy,
  input  logic [15:0] sdram_din
);

  typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

  localparam logic [2:0] ID_CHAR = 3'd0;
  localparam logic [2:0] ID_SCR1 = 3'd1;
  localparam logic [2:0] ID_SCR2 = 3'd2;
  localparam logic [2:0] ID_MAP1 = 3'd3;
  localparam logic [2:0] ID_MAP2 = 3'd4;

  state_t      state, next_state;
  logic [12:0] char_last;
  logic [16:0] scr1_last, scr2_last;
  logic [14:0] map1_last, map2_last;
  logic        char_val, scr1_val, scr2_val, map1_val, map2_val;

  logic [2:0]  lat_id;
  logic [16:0] lat_addr;
  logic [15:0] lo_word;
  logic        word_cnt;
  logic        lat_wide;
  logic        is_last;
  logic        done;

  logic        any_pend;
  logic [2:0]  win_id;
  logic [21:0] win_addr;
  logic [16:0] win_laddr;

  assign char_ok = char_val & (char_addr == char_last);
  assign scr1_ok = scr1_val & (scr1_addr == scr1_last);
  assign scr2_ok = scr2_val & (scr2_addr == scr2_last);
  assign map1_ok = map1_val & (map1_addr == map1_last);
  assign map2_ok = map2_val & (map2_addr == map2_last);

  assign lat_wide = (lat_id == ID_CHAR) || (lat_id == ID_SCR1) || (lat_id == ID_SCR2);
  assign is_last  = !lat_wide || word_cnt;
  assign done     = (state == DATA) && sdram_rdy && is_last;

  // Fixed-priority pick of the first pending port and its word address
  always_comb begin
    any_pend  = 1'b1;
    win_id    = ID_CHAR;
    win_addr  = CHAR_OFFSET + {8'd0, char_addr, 1'b0};
    win_laddr = {4'd0, char_addr};
    if (!char_ok) begin
      win_id    = ID_CHAR;
    end else if (!scr1_ok) begin
      win_id    = ID_SCR1;
      win_addr  = SCR1_OFFSET + {4'd0, scr1_addr, 1'b0};
      win_laddr = scr1_addr;
    end else if (!scr2_ok) begin
      win_id    = ID_SCR2;
      win_addr  = SCR2_OFFSET + {4'd0, scr2_addr, 1'b0};
      win_laddr = scr2_addr;
    end else if (!map1_ok) begin
      win_id    = ID_MAP1;
      win_addr  = MAP1_OFFSET + {7'd0, map1_addr};
      win_laddr = {2'd0, map1_addr};
    end else if (!map2_ok) begin
      win_id    = ID_MAP2;
      win_addr  = MAP2_OFFSET + {7'd0, map2_addr};
      win_laddr = {2'd0, map2_addr};
    end else begin
      any_pend  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (any_pend)  next_state = REQ;
      REQ:     if (sdram_gnt) next_state = DATA;
      DATA:    if (done)      next_state = IDLE;
      default:                next_state = IDLE;
    endcase
  end

  always_comb begin
    sdram_req = (state == REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_id     <= ID_CHAR;
      lat_addr   <= '0;
      sdram_addr <= '0;
      lo_word    <= '0;
      word_cnt   <= 1'b0;
      char_last  <= '0;
      scr1_last  <= '0;
      scr2_last  <= '0;
      map1_last  <= '0;
      map2_last  <= '0;
      char_val   <= 1'b0;
      scr1_val   <= 1'b0;
      scr2_val   <= 1'b0;
      map1_val   <= 1'b0;
      map2_val   <= 1'b0;
      char_data  <= '0;
      scr1_data  <= '0;
      scr2_data  <= '0;
      map1_data  <= '0;
      map2_data  <= '0;
    end else begin
      if (state == IDLE && any_pend) begin
        lat_id     <= win_id;
        lat_addr   <= win_laddr;
        sdram_addr <= win_addr;
        word_cnt   <= 1'b0;
      end
      if (state == DATA && sdram_rdy && !is_last) begin
        lo_word  <= sdram_din;
        word_cnt <= 1'b1;
      end
      // Completion stores the latched address, even if the port has moved on
      if (done) begin
        unique case (lat_id)
          ID_CHAR: begin
            char_data <= {sdram_din, lo_word};
            char_last <= lat_addr[12:0];
            char_val  <= 1'b1;
          end
          ID_SCR1: begin
            scr1_data <= {sdram_din, lo_word};
            scr1_last <= lat_addr;
            scr1_val  <= 1'b1;
          end
          ID_SCR2: begin
            scr2_data <= {sdram_din, lo_word};
            scr2_last <= lat_addr;
            scr2_val  <= 1'b1;
          end
          ID_MAP1: begin
            map1_data <= sdram_din;
            map1_last <= lat_addr[14:0];
            map1_val  <= 1'b1;
          end
          ID_MAP2: begin
            map2_data <= sdram_din;
            map2_last <= lat_addr[14:0];
            map2_val  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
